// File: rtl/alu_iter_pkg.sv
// Shared types and constants for the iterative multiply/shift unit.
package alu_iter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_SHL = 2'b01,
        OP_SHR = 2'b10,
        OP_SRA = 2'b11
    } opT;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } stateT;

endpackage

// File: rtl/alu_iter_step.sv
// Single combinational iteration: one shift-add multiply step or a one-bit shift.
module alu_iter_step
    import alu_iter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  opT               op,
    input  logic [WIDTH-1:0] hCur,
    input  logic [WIDTH-1:0] lCur,
    input  logic [WIDTH-1:0] aVal,
    output logic [WIDTH-1:0] hNext,
    output logic [WIDTH-1:0] lNext,
    output logic             lastOut
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum     = {1'b0, hCur};
        hNext   = hCur;
        lNext   = lCur;
        lastOut = 1'b0;
        case (op)
            OP_MUL: begin
                // Add A when the current multiplier bit is set, then shift {c,H,L} right.
                if (lCur[0]) begin
                    sum = {1'b0, hCur} + {1'b0, aVal};
                end
                hNext = sum[WIDTH:1];
                lNext = {sum[0], lCur[WIDTH-1:1]};
            end
            OP_SHL: begin
                lNext   = {lCur[WIDTH-2:0], 1'b0};
                lastOut = lCur[WIDTH-1];
            end
            OP_SHR: begin
                lNext   = {1'b0, lCur[WIDTH-1:1]};
                lastOut = lCur[0];
            end
            OP_SRA: begin
                lNext   = {lCur[WIDTH-1], lCur[WIDTH-1:1]};
                lastOut = lCur[0];
            end
            default: begin
                lastOut = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_iter_unit.sv
// Multi-cycle ALU back end: unsigned shift-add multiply or variable shift,
// one step per clock, with results held from Done until the next accepted Start.
module alu_iter_unit
    import alu_iter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result_Hi,
    output logic [WIDTH-1:0] Result_Lo,
    output logic             Carry,
    output logic             Zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned SH_W  = $clog2(WIDTH);

    stateT            state, nextState;
    opT               opReg, opNext;
    logic [WIDTH-1:0] aReg, aNext;
    logic [WIDTH-1:0] hReg, hNext;
    logic [WIDTH-1:0] lReg, lNext;
    logic [CNT_W-1:0] cnt, cntNext, launchCnt;

    logic             busyNext, doneNext, carryNext, zeroNext;
    logic [WIDTH-1:0] hiNext, loNext;

    logic [WIDTH-1:0] stepH, stepL;
    logic             stepOut;

    alu_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op      (opReg),
        .hCur    (hReg),
        .lCur    (lReg),
        .aVal    (aReg),
        .hNext   (stepH),
        .lNext   (stepL),
        .lastOut (stepOut)
    );

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            opReg     <= OP_MUL;
            aReg      <= '0;
            hReg      <= '0;
            lReg      <= '0;
            cnt       <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Result_Hi <= '0;
            Result_Lo <= '0;
            Carry     <= 1'b0;
            Zero      <= 1'b0;
        end else begin
            state     <= nextState;
            opReg     <= opNext;
            aReg      <= aNext;
            hReg      <= hNext;
            lReg      <= lNext;
            cnt       <= cntNext;
            Busy      <= busyNext;
            Done      <= doneNext;
            Result_Hi <= hiNext;
            Result_Lo <= loNext;
            Carry     <= carryNext;
            Zero      <= zeroNext;
        end
    end

    always_comb begin
        nextState = state;
        opNext    = opReg;
        aNext     = aReg;
        hNext     = hReg;
        lNext     = lReg;
        cntNext   = cnt;
        launchCnt = '0;
        hiNext    = Result_Hi;
        loNext    = Result_Lo;
        carryNext = Carry;
        zeroNext  = Zero;

        case (state)
            IDLE: begin
                if (Start) begin
                    opNext = opT'(Op);
                    aNext  = OperandA;
                    hNext  = '0;
                    if (opT'(Op) == OP_MUL) begin
                        lNext     = OperandB;
                        launchCnt = CNT_W'(WIDTH);
                    end else begin
                        lNext     = OperandA;
                        launchCnt = CNT_W'(OperandB[SH_W-1:0]);
                    end
                    cntNext = launchCnt;
                    // A zero-count shift finishes immediately with the operand unchanged.
                    if (launchCnt == '0) begin
                        nextState = DONE;
                        hiNext    = '0;
                        loNext    = OperandA;
                        carryNext = 1'b0;
                        zeroNext  = (OperandA == '0);
                    end else begin
                        nextState = RUN;
                    end
                end
            end
            RUN: begin
                hNext   = stepH;
                lNext   = stepL;
                cntNext = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    nextState = DONE;
                    if (opReg == OP_MUL) begin
                        hiNext    = stepH;
                        loNext    = stepL;
                        carryNext = (stepH != '0);
                    end else begin
                        hiNext    = '0;
                        loNext    = stepL;
                        carryNext = stepOut;
                    end
                    zeroNext = (hiNext == '0) && (loNext == '0);
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase

        busyNext = (nextState == RUN);
        doneNext = (nextState == DONE);
    end

endmodule

// File: tb/tb_alu_iter_unit.sv
// Directed bench for alu_iter_unit: latency, handshake, reset abort and result values.
module tb_alu_iter_unit;
    import alu_iter_pkg::*;

    localparam int unsigned W = 8;

    logic         CLK = 1'b0;
    logic         Reset_n;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] OperandA;
    logic [W-1:0] OperandB;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result_Hi;
    logic [W-1:0] Result_Lo;
    logic         Carry;
    logic         Zero;

    int nChecks = 0;
    int nPass   = 0;

    always #5 CLK = ~CLK;

    alu_iter_unit #(
        .WIDTH (W)
    ) dut (
        .CLK       (CLK),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Op        (Op),
        .OperandA  (OperandA),
        .OperandB  (OperandB),
        .Busy      (Busy),
        .Done      (Done),
        .Result_Hi (Result_Hi),
        .Result_Lo (Result_Lo),
        .Carry     (Carry),
        .Zero      (Zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Launch one operation, scramble inputs afterwards, and verify latency, Busy length and results.
    task automatic runOp(input string tag, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int expLat, input bit toggle,
                         input logic [7:0] expHi, input logic [7:0] expLo, input logic expC, input logic expZ);
        int lat;
        int busyCnt;
        lat     = -1;
        busyCnt = 0;
        @(negedge CLK);
        Start = 1'b1; Op = op; OperandA = a; OperandB = b;
        @(posedge CLK); #1;
        Start = 1'b0; Op = ~op; OperandA = ~a; OperandB = ~b;
        for (int j = 0; j < 40; j++) begin
            if (Done) begin
                lat = j;
                break;
            end
            if (Busy) busyCnt++;
            Start = (toggle && Busy) ? 1'(j & 1) : 1'b0;
            @(posedge CLK); #1;
        end
        Start = 1'b0;
        check({tag, "_lat"}, lat, expLat);
        check({tag, "_busy"}, busyCnt, expLat);
        check({tag, "_hi"}, Result_Hi, expHi);
        check({tag, "_lo"}, Result_Lo, expLo);
        check({tag, "_cz"}, {Carry, Zero}, {expC, expZ});
        @(posedge CLK); #1;
        check({tag, "_pulse"}, {Done, Busy}, 2'b00);
        check({tag, "_hold"}, {Result_Hi, Result_Lo}, {expHi, expLo});
    endtask

    initial begin
        int doneCnt;
        int firstDone;
        int prevDone;
        int spacingBad;
        int holdBad;
        int stray;

        Reset_n = 1'b0; Start = 1'b0; Op = 2'b00; OperandA = '0; OperandB = '0;
        #12;
        check("rst_outputs", {Busy, Done, Carry, Zero, Result_Hi, Result_Lo}, '0);
        @(negedge CLK); Reset_n = 1'b1;
        @(posedge CLK); #1;
        check("rst_idle", {Busy, Done}, 2'b00);

        // 255*255 = 0xFE01
        runOp("mul_ff", OP_MUL, 8'hFF, 8'hFF, 8, 1'b0, 8'hFE, 8'h01, 1'b1, 1'b0);

        // Abort a multiply mid-flight with an asynchronous reset.
        @(negedge CLK);
        Start = 1'b1; Op = OP_MUL; OperandA = 8'h12; OperandB = 8'h34;
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check("abort_busy", Busy, 1'b1);
        #2 Reset_n = 1'b0;
        #1;
        check("abort_outputs", {Busy, Done, Carry, Zero, Result_Hi, Result_Lo}, '0);
        @(negedge CLK); Reset_n = 1'b1;
        stray = 0;
        repeat (15) begin
            @(posedge CLK); #1;
            if (Done || Busy) stray++;
        end
        check("abort_no_done", stray, 0);
        // 0x12*0x34 = 936 = 0x03A8
        runOp("mul_after_rst", OP_MUL, 8'h12, 8'h34, 8, 1'b0, 8'h03, 8'hA8, 1'b1, 1'b0);

        runOp("mul_zero", OP_MUL, 8'h00, 8'h37, 8, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        runOp("mul_one", OP_MUL, 8'h01, 8'h37, 8, 1'b0, 8'h00, 8'h37, 1'b0, 1'b0);
        // 0xA5*0x3C = 9900 = 0x26AC, with Start toggling while busy
        runOp("mul_tog", OP_MUL, 8'hA5, 8'h3C, 8, 1'b1, 8'h26, 8'hAC, 1'b1, 1'b0);

        runOp("shl_81", OP_SHL, 8'h81, 8'h01, 1, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0);
        runOp("shl_80", OP_SHL, 8'h80, 8'h01, 1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        runOp("sra_80", OP_SRA, 8'h80, 8'h03, 3, 1'b0, 8'h00, 8'hF0, 1'b0, 1'b0);
        runOp("sra_c3", OP_SRA, 8'hC3, 8'h02, 2, 1'b0, 8'h00, 8'hF0, 1'b1, 1'b0);
        runOp("shr_80", OP_SHR, 8'h80, 8'hFF, 7, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);
        runOp("shr_cnt0", OP_SHR, 8'h5A, 8'hF8, 0, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0);

        // Start held high: 13*11 = 143 = 0x8F re-launched every N+2 = 10 cycles.
        doneCnt = 0; firstDone = -1; prevDone = -1; spacingBad = 0; holdBad = 0;
        @(negedge CLK);
        Start = 1'b1; Op = OP_MUL; OperandA = 8'h0D; OperandB = 8'h0B;
        @(posedge CLK); #1;
        for (int j = 0; j < 30; j++) begin
            if (Done) begin
                doneCnt++;
                if (firstDone < 0) firstDone = j;
                if (prevDone >= 0 && (j - prevDone) != 10) spacingBad++;
                prevDone = j;
            end
            if (j >= 8 && (Result_Lo !== 8'h8F || Result_Hi !== 8'h00)) holdBad++;
            if (j == 29) Start = 1'b0;
            @(posedge CLK); #1;
        end
        Start = 1'b0;
        check("b2b_count", doneCnt, 3);
        check("b2b_first", firstDone, 8);
        check("b2b_last", prevDone, 28);
        check("b2b_spacing", spacingBad, 0);
        check("b2b_hold", holdBad, 0);
        repeat (12) @(posedge CLK);
        #1;
        check("b2b_idle", {Busy, Done}, 2'b00);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
